// File: rtl/prt_pkg.sv
// prt_pkg -- shared types for the PRT egress drain.
//   slot_t      : PRT slot index (sized for NUM_SLOTS_DEF slots)
//   state_t     : drain FSM states
//   decision_t  : packed {slot, forward} decision as queued in the decision FIFO
//   slot_width(): slot index width for a given slot count, never below 1
package prt_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int NUM_SLOTS_DEF  = 2;

    function automatic int slot_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int SLOT_W_DEF = slot_width(NUM_SLOTS_DEF);

    // The decision datapath carries slots as slot_t; keep NUM_SLOTS_DEF in
    // step with the NUM_SLOTS the top is built with.
    typedef logic [SLOT_W_DEF-1:0] slot_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        READ,
        DRAIN,
        INVAL
    } state_t;

    typedef struct packed {
        slot_t slot;
        logic  forward;
    } decision_t;

endpackage

// File: rtl/prt_decision_fifo.sv
// prt_decision_fifo -- synchronous FIFO of forward/drop decisions.
//   clk, rst : clock, synchronous active-high reset (empties the FIFO)
//   push     : write din when not full (push while full is dropped)
//   pop      : advance read side when not empty
//   din/dout : decision in / decision at the head (valid when !empty)
//   full     : DEPTH entries held
//   empty    : no entries held
// A push and a pop in the same cycle are both honoured.
module prt_decision_fifo
    import prt_pkg::*;
#(
    parameter int DEPTH = 2
)(
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  decision_t din,
    output decision_t dout,
    output logic      full,
    output logic      empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    decision_t     mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push)
                wptr <= (wptr == AW'(DEPTH-1)) ? '0 : wptr + 1'b1;
            if (do_pop)
                rptr <= (rptr == AW'(DEPTH-1)) ? '0 : rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once written.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wptr] <= din;
    end

endmodule

// File: rtl/prt_tx_drain.sv
// prt_tx_drain -- egress stage behind the PRT.
// Pops forward/drop decisions; forwards stream the slot's bytes out on tx_*
// (tx_last on the final byte), then every decision frees its slot.
//   CLK, RST                      : clock, synchronous active-high reset
//   EN/RDY_put_decision, put_*    : decision enqueue (RDY = FIFO not full)
//   EN/RDY_start_reading_prt_entry: open a slot for reading
//   EN/RDY_read_prt_entry         : consume one PRT word {end, byte}
//   EN/RDY_invalidate_prt_entry   : free the latched slot
//   tx_data/valid/last, tx_ready  : egress valid/ready byte stream
//   tx_pkt_count, drop_pkt_count  : saturating packet counters
// Build option PRT_TX_STATS_EN: when defined the counters are live,
// otherwise they are not built and the ports read 0.
module prt_tx_drain
    import prt_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int NUM_SLOTS  = NUM_SLOTS_DEF,
    parameter int DEC_DEPTH  = 2,
    localparam int SLOT_W    = slot_width(NUM_SLOTS)
)(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  EN_put_decision,
    input  logic [SLOT_W-1:0]     put_decision_slot,
    input  logic                  put_decision_forward,
    output logic                  RDY_put_decision,
    output logic                  EN_start_reading_prt_entry,
    output logic [SLOT_W-1:0]     start_reading_prt_entry_slot,
    input  logic                  RDY_start_reading_prt_entry,
    output logic                  EN_read_prt_entry,
    input  logic [DATA_WIDTH:0]   read_prt_entry,
    input  logic                  RDY_read_prt_entry,
    output logic                  EN_invalidate_prt_entry,
    output logic [SLOT_W-1:0]     invalidate_prt_entry_slot,
    input  logic                  RDY_invalidate_prt_entry,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    output logic                  tx_last,
    input  logic                  tx_ready,
    output logic [31:0]           tx_pkt_count,
    output logic [31:0]           drop_pkt_count
);

    state_t                state;
    state_t                state_nxt;
    slot_t                 slot_q;
    decision_t             fifo_din;
    decision_t             fifo_dout;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_pop;
    logic                  pend_vld;
    logic [DATA_WIDTH-1:0] pend_data;
    logic                  out_vld;
    logic                  out_last;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_free;
    logic                  rd_end;

    assign fifo_din = {slot_t'(put_decision_slot), put_decision_forward};

    prt_decision_fifo #(
        .DEPTH (DEC_DEPTH)
    ) u_dec_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (EN_put_decision),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign RDY_put_decision             = !fifo_full;
    assign start_reading_prt_entry_slot = SLOT_W'(slot_q);
    assign invalidate_prt_entry_slot    = SLOT_W'(slot_q);
    assign tx_data                      = out_data;
    assign tx_valid                     = out_vld;
    assign tx_last                      = out_last;
    assign out_free                     = !out_vld || tx_ready;
    assign rd_end                       = read_prt_entry[DATA_WIDTH];

    always_comb begin
        state_nxt                  = state;
        fifo_pop                   = 1'b0;
        EN_start_reading_prt_entry = 1'b0;
        EN_read_prt_entry          = 1'b0;
        EN_invalidate_prt_entry    = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    state_nxt = fifo_dout.forward ? START : INVAL;
                end
            end
            START: begin
                EN_start_reading_prt_entry = RDY_start_reading_prt_entry;
                if (RDY_start_reading_prt_entry)
                    state_nxt = READ;
            end
            READ: begin
                // A word may only be taken if pend has somewhere to go.
                EN_read_prt_entry = RDY_read_prt_entry && (!pend_vld || out_free);
                if (EN_read_prt_entry && rd_end)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!out_vld || (tx_ready && out_last))
                    state_nxt = INVAL;
            end
            INVAL: begin
                EN_invalidate_prt_entry = RDY_invalidate_prt_entry;
                if (RDY_invalidate_prt_entry)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // pend holds one byte of lookahead so the byte before the end word can
    // be tagged last when it moves into out.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            slot_q    <= '0;
            pend_vld  <= 1'b0;
            pend_data <= '0;
            out_vld   <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            state <= state_nxt;
            if (fifo_pop)
                slot_q <= fifo_dout.slot;
            if (EN_read_prt_entry && pend_vld) begin
                out_vld  <= 1'b1;
                out_data <= pend_data;
                out_last <= rd_end;
            end else if (tx_ready) begin
                out_vld <= 1'b0;
            end
            if (EN_read_prt_entry) begin
                pend_vld  <= !rd_end;
                pend_data <= read_prt_entry[DATA_WIDTH-1:0];
            end
        end
    end

`ifdef PRT_TX_STATS_EN
    logic        fwd_q;
    logic [31:0] tx_cnt;
    logic [31:0] drop_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            fwd_q    <= 1'b0;
            tx_cnt   <= '0;
            drop_cnt <= '0;
        end else begin
            if (fifo_pop)
                fwd_q <= fifo_dout.forward;
            if (EN_invalidate_prt_entry) begin
                if (fwd_q && (tx_cnt != '1))
                    tx_cnt <= tx_cnt + 32'd1;
                else if (!fwd_q && (drop_cnt != '1))
                    drop_cnt <= drop_cnt + 32'd1;
            end
        end
    end

    assign tx_pkt_count   = tx_cnt;
    assign drop_pkt_count = drop_cnt;
`else
    assign tx_pkt_count   = '0;
    assign drop_pkt_count = '0;
`endif

endmodule

// File: tb/tb_prt_tx_drain.sv
// tb_prt_tx_drain -- self-checking bench for prt_tx_drain.
// A behavioural PRT (slot byte arrays) feeds the DUT; every accepted decision
// is expanded into the expected egress byte stream, start-read order and
// invalidate order, which a scoreboard checks as handshakes happen.
// Directed table entries, hand-written corner sequences, then random traffic.
module tb_prt_tx_drain;

    localparam int DW = 8;
    localparam int NS = 2;
    localparam int DD = 2;
    localparam int SW = 1;
    localparam int MAXLEN = 32;

    logic          CLK = 1'b0;
    logic          RST;
    logic          EN_put_decision;
    logic [SW-1:0] put_decision_slot;
    logic          put_decision_forward;
    logic          RDY_put_decision;
    logic          EN_start_reading_prt_entry;
    logic [SW-1:0] start_reading_prt_entry_slot;
    logic          RDY_start_reading_prt_entry;
    logic          EN_read_prt_entry;
    logic [DW:0]   read_prt_entry;
    logic          RDY_read_prt_entry;
    logic          EN_invalidate_prt_entry;
    logic [SW-1:0] invalidate_prt_entry_slot;
    logic          RDY_invalidate_prt_entry;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_last;
    logic          tx_ready;
    logic [31:0]   tx_pkt_count;
    logic [31:0]   drop_pkt_count;

    prt_tx_drain #(.DATA_WIDTH(DW), .NUM_SLOTS(NS), .DEC_DEPTH(DD)) dut (
        .CLK                          (CLK),
        .RST                          (RST),
        .EN_put_decision              (EN_put_decision),
        .put_decision_slot            (put_decision_slot),
        .put_decision_forward         (put_decision_forward),
        .RDY_put_decision             (RDY_put_decision),
        .EN_start_reading_prt_entry   (EN_start_reading_prt_entry),
        .start_reading_prt_entry_slot (start_reading_prt_entry_slot),
        .RDY_start_reading_prt_entry  (RDY_start_reading_prt_entry),
        .EN_read_prt_entry            (EN_read_prt_entry),
        .read_prt_entry               (read_prt_entry),
        .RDY_read_prt_entry           (RDY_read_prt_entry),
        .EN_invalidate_prt_entry      (EN_invalidate_prt_entry),
        .invalidate_prt_entry_slot    (invalidate_prt_entry_slot),
        .RDY_invalidate_prt_entry     (RDY_invalidate_prt_entry),
        .tx_data                      (tx_data),
        .tx_valid                     (tx_valid),
        .tx_last                      (tx_last),
        .tx_ready                     (tx_ready),
        .tx_pkt_count                 (tx_pkt_count),
        .drop_pkt_count               (drop_pkt_count)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    // behavioural PRT
    int         prt_len [NS];
    logic [7:0] prt_data [NS][MAXLEN];
    logic       rd_active = 1'b0;
    int         rd_slot = 0;
    int         rd_idx = 0;

    // stimulus knobs (percent probabilities, tx_ready mode)
    int   p_start = 100, p_read = 100, p_inval = 100, tx_mode = 0;
    logic tx_tog = 1'b1;
    logic          put_req = 1'b0;
    logic [SW-1:0] put_s = '0;
    logic          put_f = 1'b0;
    logic          put_exp_rdy = 1'b1;

    // reference model state
    logic [8:0] exp_tx[$];
    int         exp_start[$];
    int         exp_inval[$];
    int         busy_cnt [NS];
    int         outstanding = 0;
    int         exp_tx_cnt = 0, exp_drop_cnt = 0;

    // event record
    int n_tx, n_last, n_start, n_read, n_inval;
    int c_put, c_start, c_read, c_tx_first, c_tx_last, c_inval, last_inval_slot;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic       prev_last;

    typedef struct {
        int slot;
        bit fwd;
        int len;
        int base;
        int mode;
        int e_bytes;
        int e_lasts;
        int e_starts;
        int e_inval_slot;
    } vec_t;

    function automatic bit roll(input int p);
        return $urandom_range(99) < p;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clr_events();
        n_tx = 0; n_last = 0; n_start = 0; n_read = 0; n_inval = 0;
        c_put = -1; c_start = -1; c_read = -1; c_tx_first = -1; c_tx_last = -1;
        c_inval = -1; last_inval_slot = -1;
    endtask

    task automatic fill(input int s, input int len, input int base, input bit rnd);
        prt_len[s] = len;
        for (int k = 0; k < len; k++)
            prt_data[s][k] = rnd ? 8'($urandom_range(255)) : 8'(base + k);
    endtask

    // Reference: what one accepted decision must eventually produce.
    task automatic accept(input int s, input bit f);
        outstanding++;
        busy_cnt[s]++;
        c_put = cyc;
        exp_inval.push_back(s);
        if (f) begin
            exp_tx_cnt++;
            exp_start.push_back(s);
            for (int k = 0; k < prt_len[s]; k++)
                exp_tx.push_back({(k == prt_len[s] - 1), prt_data[s][k]});
        end else begin
            exp_drop_cnt++;
        end
    endtask

    task automatic observe();
        if (RST) begin
            prev_stall = 1'b0;
            return;
        end
        if (EN_put_decision) begin
            chk("rdy_put", RDY_put_decision, put_exp_rdy);
            if (put_exp_rdy)
                accept(int'(put_s), put_f);
        end
        if (prev_stall) begin
            chk("tx_hold_valid", tx_valid, 1);
            chk("tx_hold_data", {tx_last, tx_data}, {prev_last, prev_data});
        end
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
        prev_last  = tx_last;
        if (tx_valid && tx_ready) begin
            n_tx++;
            if (tx_last) n_last++;
            if (n_tx == 1) c_tx_first = cyc;
            c_tx_last = cyc;
            if (exp_tx.size() == 0) chk("tx_extra", {tx_last, tx_data}, 9'h1ff);
            else chk("tx_byte", {tx_last, tx_data}, exp_tx.pop_front());
        end
        if (EN_read_prt_entry) begin
            chk("read_rdy", RDY_read_prt_entry, 1);
            n_read++;
            if (n_read == 1) c_read = cyc;
            if (rd_active) begin
                if (rd_idx >= prt_len[rd_slot]) rd_active = 1'b0;
                else rd_idx++;
            end
        end
        if (EN_start_reading_prt_entry) begin
            chk("start_rdy", RDY_start_reading_prt_entry, 1);
            n_start++;
            if (n_start == 1) c_start = cyc;
            if (exp_start.size() == 0) chk("start_extra", 1, 0);
            else chk("start_slot", start_reading_prt_entry_slot, exp_start.pop_front());
            rd_active = 1'b1;
            rd_slot   = int'(start_reading_prt_entry_slot);
            rd_idx    = 0;
        end
        if (EN_invalidate_prt_entry) begin
            chk("inval_rdy", RDY_invalidate_prt_entry, 1);
            n_inval++;
            c_inval = cyc;
            last_inval_slot = int'(invalidate_prt_entry_slot);
            if (exp_inval.size() == 0) chk("inval_extra", 1, 0);
            else begin
                busy_cnt[exp_inval[0]]--;
                chk("inval_slot", invalidate_prt_entry_slot, exp_inval.pop_front());
            end
            outstanding--;
        end
    endtask

    // One clock: drive at the falling edge, sample just before the rising edge.
    task automatic cycle();
        @(negedge CLK);
        RDY_start_reading_prt_entry = !rd_active && roll(p_start);
        RDY_read_prt_entry = rd_active && roll(p_read);
        if (rd_active && rd_idx < prt_len[rd_slot])
            read_prt_entry = {1'b0, prt_data[rd_slot][rd_idx]};
        else
            read_prt_entry = {1'b1, 8'($urandom_range(255))};
        RDY_invalidate_prt_entry = roll(p_inval);
        case (tx_mode)
            0: tx_ready = 1'b1;
            1: begin tx_ready = tx_tog; tx_tog = !tx_tog; end
            default: tx_ready = roll(60);
        endcase
        EN_put_decision      = put_req;
        put_decision_slot    = put_s;
        put_decision_forward = put_f;
        #1;
        observe();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic put1(input int s, input bit f, input bit exp_rdy);
        put_req = 1'b1; put_s = SW'(s); put_f = f; put_exp_rdy = exp_rdy;
        cycle();
        put_req = 1'b0; put_exp_rdy = 1'b1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        cycle();
        RST = 1'b0;
        exp_tx.delete(); exp_start.delete(); exp_inval.delete();
        for (int s = 0; s < NS; s++) busy_cnt[s] = 0;
        outstanding = 0; exp_tx_cnt = 0; exp_drop_cnt = 0;
        rd_active = 1'b0; prev_stall = 1'b0;
        clr_events();
    endtask

    task automatic drain(input int bound);
        int k = 0;
        while (outstanding != 0 && k < bound) begin
            cycle();
            k++;
        end
        if (outstanding != 0) chk("drain_timeout", outstanding, 0);
        repeat (3) cycle();
    endtask

    task automatic check_counts();
`ifdef PRT_TX_STATS_EN
        chk("tx_pkt_count", tx_pkt_count, exp_tx_cnt);
        chk("drop_pkt_count", drop_pkt_count, exp_drop_cnt);
`else
        chk("tx_pkt_count", tx_pkt_count, 0);
        chk("drop_pkt_count", drop_pkt_count, 0);
`endif
    endtask

    task automatic check_reset_outputs();
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_last", tx_last, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_en_start", EN_start_reading_prt_entry, 0);
        chk("rst_en_read", EN_read_prt_entry, 0);
        chk("rst_en_inval", EN_invalidate_prt_entry, 0);
        chk("rst_start_slot", start_reading_prt_entry_slot, 0);
        chk("rst_inval_slot", invalidate_prt_entry_slot, 0);
        chk("rst_rdy_put", RDY_put_decision, 1);
        chk("rst_tx_pkt_count", tx_pkt_count, 0);
        chk("rst_drop_pkt_count", drop_pkt_count, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[5];
        int   k;
        int   sent;

        RST = 1'b1;
        EN_put_decision = 1'b0; put_decision_slot = '0; put_decision_forward = 1'b0;
        RDY_start_reading_prt_entry = 1'b0; RDY_read_prt_entry = 1'b0;
        RDY_invalidate_prt_entry = 1'b0; read_prt_entry = '0; tx_ready = 1'b0;
        for (int s = 0; s < NS; s++) begin
            busy_cnt[s] = 0;
            fill(s, 0, 0, 1'b0);
        end
        clr_events();

        // reset state
        repeat (2) do_reset();
        check_reset_outputs();

        // {slot, fwd, len, base, tx_mode, bytes, lasts, starts, inval slot}
        vt[0] = '{0, 1'b1, 5,   0,   0, 5,  1, 1, 0};
        vt[1] = '{1, 1'b1, 0,   0,   0, 0,  0, 1, 1};
        vt[2] = '{1, 1'b0, 3,   50,  0, 0,  0, 0, 1};
        vt[3] = '{0, 1'b1, 20,  200, 1, 20, 1, 1, 0};
        vt[4] = '{1, 1'b1, 1,   170, 2, 1,  1, 1, 1};
        for (int i = 0; i < 5; i++) begin
            fill(vt[i].slot, vt[i].len, vt[i].base, 1'b0);
            tx_mode = vt[i].mode;
            tx_tog  = 1'b1;
            clr_events();
            put1(vt[i].slot, vt[i].fwd, 1'b1);
            drain(300);
            chk("vec_bytes", n_tx, vt[i].e_bytes);
            chk("vec_lasts", n_last, vt[i].e_lasts);
            chk("vec_starts", n_start, vt[i].e_starts);
            chk("vec_invals", n_inval, 1);
            chk("vec_inval_slot", last_inval_slot, vt[i].e_inval_slot);
            if (vt[i].mode == 0 && vt[i].fwd && vt[i].len > 0) begin
                chk("lat_start", c_start - c_put, 2);
                chk("lat_read", c_read - c_put, 3);
                chk("lat_tx_first", c_tx_first - c_put, 5);
                chk("lat_tx_span", c_tx_last - c_tx_first, vt[i].len - 1);
                chk("lat_inval", c_inval - c_tx_last, 1);
            end
            if (!vt[i].fwd)
                chk("lat_drop_inval", c_inval - c_put, 2);
            check_counts();
        end

        // FIFO full: d0 stuck in START, then three back-to-back puts
        tx_mode = 0;
        p_start = 0;
        fill(0, 3, 10, 1'b0);
        fill(1, 2, 20, 1'b0);
        clr_events();
        put1(0, 1'b1, 1'b1);
        repeat (2) cycle();
        put1(1, 1'b1, 1'b1);
        put1(0, 1'b0, 1'b1);
        put1(1, 1'b1, 1'b0);
        repeat (4) cycle();
        chk("full_no_start", n_start, 0);
        chk("full_rdy_put_low", RDY_put_decision, 0);
        p_start = 100;
        drain(300);
        chk("full_invals", n_inval, 3);
        chk("full_bytes", n_tx, 5);
        check_counts();

        // reset after byte 2 of a 5-byte packet
        fill(0, 5, 48, 1'b0);
        clr_events();
        put1(0, 1'b1, 1'b1);
        k = 0;
        while (n_tx < 3 && k < 50) begin
            cycle();
            k++;
        end
        chk("rst_mid_reached", n_tx, 3);
        do_reset();
        check_reset_outputs();
        repeat (10) cycle();
        chk("rst_mid_no_inval", n_inval, 0);
        chk("rst_mid_no_start", n_start, 0);
        chk("rst_mid_no_tx", n_tx, 0);
        chk("rst_mid_fifo_empty", RDY_put_decision, 1);

        // random traffic against the reference
        tx_mode = 2; p_start = 70; p_read = 70; p_inval = 70;
        sent = 0;
        k = 0;
        while (sent < 60 && k < 20000) begin
            put_req = 1'b0;
            if (outstanding < DD && $urandom_range(2) == 0) begin
                int s;
                s = $urandom_range(NS - 1);
                if (busy_cnt[s] == 0) begin
                    fill(s, $urandom_range(8), 0, 1'b1);
                    put_req = 1'b1;
                    put_s = SW'(s);
                    put_f = 1'($urandom_range(1));
                    put_exp_rdy = 1'b1;
                    sent++;
                end
            end
            cycle();
            k++;
        end
        put_req = 1'b0;
        chk("rand_sent", sent, 60);
        drain(3000);
        chk("rand_tx_left", exp_tx.size(), 0);
        chk("rand_start_left", exp_start.size(), 0);
        check_counts();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
